// File: rtl/linebuf_sched_pkg.sv
// Shared definitions for the sprite line double buffer: default geometry,
// the transparent/erase code, write-port source encoding and the helper that
// forms a RAM address from a bank select and an x position.
package linebuf_sched_pkg;

  localparam int         XW_DEF     = 9;
  localparam int         DW_DEF     = 7;
  localparam logic [6:0] TRANSP_DEF = 7'd0;

  // Owner of the single RAM write port in a given cycle.
  typedef enum logic [1:0] {
    WR_NONE   = 2'd0,
    WR_ERASE  = 2'd1,
    WR_SPRITE = 2'd2
  } wr_src_t;

  // Bank select is the RAM address MSB; renderer and mixer both use this.
  function automatic logic [XW_DEF:0] bank_addr(input logic sel, input logic [XW_DEF-1:0] x);
    return {sel, x};
  endfunction

endpackage

// File: rtl/linebuf_sched_if.sv
// Bundle of the video-timing, renderer, mixer and line-buffer RAM signals
// around the scheduler. The scheduler takes the slave view.
interface linebuf_sched_if
  import linebuf_sched_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int DW = DW_DEF
);
  // Video timing and mixer side
  logic          PCE;
  logic          HBLK;
  logic [XW-1:0] HPOS;
  logic [DW-1:0] DOUT;
  // Sprite renderer side
  logic          SREQ;
  logic [XW-1:0] SX;
  logic [DW-1:0] SD;
  logic          SRDY;
  logic          SDONE;
  logic          SSTART;
  logic          LATE;
  // Line buffer RAM side
  logic [XW:0]   BRA;
  logic          BRE;
  logic [DW-1:0] BRD;
  logic [XW:0]   BWA;
  logic [DW-1:0] BWD;
  logic          BWE;

  modport slave (
    input  PCE, HBLK, HPOS, SREQ, SX, SD, SDONE, BRD,
    output DOUT, SRDY, SSTART, LATE, BRA, BRE, BWA, BWD, BWE
  );

  modport master (
    output PCE, HBLK, HPOS, SREQ, SX, SD, SDONE, BRD,
    input  DOUT, SRDY, SSTART, LATE, BRA, BRE, BWA, BWD, BWE
  );

endinterface

// File: rtl/linebuf_sched_wrarb.sv
// Write-port arbiter: a pending erase-after-read always owns the port; the
// sprite renderer is only acknowledged when the port is free and the banks
// are not swapping this cycle. Transparent sprite pixels are acknowledged but
// never reach the RAM, so back-to-front ordering with "last write wins" holds.
module linebuf_sched_wrarb
  import linebuf_sched_pkg::*;
#(
  parameter int            XW     = XW_DEF,
  parameter int            DW     = DW_DEF,
  parameter logic [DW-1:0] TRANSP = TRANSP_DEF
) (
  input  logic          run,
  input  logic          clr_pend,
  input  logic [XW:0]   clr_addr,
  input  logic          swap,
  input  logic          bsel,
  input  logic          sreq,
  input  logic [XW-1:0] sx,
  input  logic [DW-1:0] sd,
  output logic          srdy,
  output logic [XW:0]   bwa,
  output logic [DW-1:0] bwd,
  output logic          bwe
);

  logic    srdy_s;
  wr_src_t wr_src_s;

  assign srdy_s = run & ~clr_pend & ~swap;
  assign srdy   = srdy_s;

  // Choose the write-port owner: erase first, then a non-transparent sprite pixel.
  always_comb begin
    wr_src_s = WR_NONE;
    if (clr_pend) begin
      wr_src_s = WR_ERASE;
    end else if (sreq && srdy_s && (sd != TRANSP)) begin
      wr_src_s = WR_SPRITE;
    end else begin
      wr_src_s = WR_NONE;
    end
  end

  // Steer address/data/enable from the selected owner; sprites target the back bank.
  always_comb begin
    bwa = {(XW+1){1'b0}};
    bwd = TRANSP;
    bwe = 1'b0;
    case (wr_src_s)
      WR_ERASE: begin
        bwa = clr_addr;
        bwd = TRANSP;
        bwe = 1'b1;
      end
      WR_SPRITE: begin
        bwa = bank_addr(~bsel, sx);
        bwd = sd;
        bwe = 1'b1;
      end
      default: begin
        bwa = {(XW+1){1'b0}};
        bwd = TRANSP;
        bwe = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/linebuf_sched.sv
// Sprite line double-buffer scheduler. The front bank (bsel) is read out to
// the mixer one pixel per PCE and erased right behind the read; the back bank
// receives sprite pixels. Banks swap on each rising edge of HBLK, at which
// point the renderer is told to start the next line and, if it never reported
// finishing the previous one, LATE is flagged.
module linebuf_sched
  import linebuf_sched_pkg::*;
#(
  parameter int            XW     = XW_DEF,
  parameter int            DW     = DW_DEF,
  parameter logic [DW-1:0] TRANSP = TRANSP_DEF
) (
  input  logic           CL,
  input  logic           RST_N,
  linebuf_sched_if.slave bus
);

  logic          bsel_r;
  logic          hblk_d_r;
  logic          clr_pend_r;
  logic [XW:0]   clr_addr_r;
  logic          rd_pend_r;
  logic          done_seen_r;
  logic          run_r;
  logic          sstart_r;
  logic          late_r;
  logic [DW-1:0] dout_r;

  logic          swap_s;
  logic          bre_s;
  logic [XW:0]   bra_s;

  // First blank cycle of a line; hblk_d resets high so a blank in progress
  // at reset release does not count as a new edge.
  assign swap_s = bus.HBLK & ~hblk_d_r;
  assign bre_s  = bus.PCE & ~bus.HBLK;
  assign bra_s  = bank_addr(bsel_r, bus.HPOS);

  assign bus.BRE    = bre_s;
  assign bus.BRA    = bra_s;
  assign bus.DOUT   = dout_r;
  assign bus.SSTART = sstart_r;
  assign bus.LATE   = late_r;

  linebuf_sched_wrarb #(
    .XW     (XW),
    .DW     (DW),
    .TRANSP (TRANSP)
  ) u_wrarb (
    .run      (run_r),
    .clr_pend (clr_pend_r),
    .clr_addr (clr_addr_r),
    .swap     (swap_s),
    .bsel     (bsel_r),
    .sreq     (bus.SREQ),
    .sx       (bus.SX),
    .sd       (bus.SD),
    .srdy     (bus.SRDY),
    .bwa      (bus.BWA),
    .bwd      (bus.BWD),
    .bwe      (bus.BWE)
  );

  // Bank ping-pong, blank edge tracking and renderer start/late pulses.
  // An SDONE arriving on the swap cycle still belongs to the finishing line.
  always_ff @(posedge CL or negedge RST_N) begin
    if (!RST_N) begin
      bsel_r      <= 1'b0;
      hblk_d_r    <= 1'b1;
      done_seen_r <= 1'b1;
      run_r       <= 1'b0;
      sstart_r    <= 1'b0;
      late_r      <= 1'b0;
    end else begin
      run_r    <= 1'b1;
      hblk_d_r <= bus.HBLK;
      sstart_r <= swap_s;
      if (swap_s) begin
        bsel_r      <= ~bsel_r;
        late_r      <= ~(done_seen_r | bus.SDONE);
        done_seen_r <= 1'b0;
      end else begin
        late_r <= 1'b0;
        if (bus.SDONE) begin
          done_seen_r <= 1'b1;
        end
      end
    end
  end

  // Remember each display read so its data can be captured and its location erased next cycle.
  always_ff @(posedge CL or negedge RST_N) begin
    if (!RST_N) begin
      clr_pend_r <= 1'b0;
      clr_addr_r <= {(XW+1){1'b0}};
      rd_pend_r  <= 1'b0;
    end else begin
      clr_pend_r <= bre_s;
      clr_addr_r <= bra_s;
      rd_pend_r  <= bre_s;
    end
  end

  // Displayed pixel: blanked on the first HBLK cycle, otherwise loads returning read data.
  always_ff @(posedge CL or negedge RST_N) begin
    if (!RST_N) begin
      dout_r <= TRANSP;
    end else if (swap_s) begin
      dout_r <= TRANSP;
    end else if (rd_pend_r) begin
      dout_r <= bus.BRD;
    end
  end

endmodule

// File: doc/linebuf_sched.md
# linebuf_sched

Scheduler for the sprite line double buffer (two 512×7 banks in one 1024-entry dual-port RAM). It ping-pongs the banks at each horizontal blank. It also owns the single write port, arbitrating between display-side erase-after-read and sprite-engine pixel writes. It sits between the sprite renderer, the video timing generator and the line buffer RAM; the mixer consumes DOUT.

## Interface
Parameters:
- XW, 9: x-address width per bank; RAM address is XW+1 bits.
- DW, 7: pixel width.
- TRANSP, 0: transparent pixel code, also the erase value.

Ports:
- CL  in  1  system clock, the only clock.
- RST_N  in  1  asynchronous, active-low reset.
- PCE  in  1  pixel clock enable, one display pixel per PCE.
- HBLK  in  1  horizontal blank from video timing.
- HPOS  in  XW  display x position.
- DOUT  out  DW  displayed pixel, registered.
- SREQ  in  1  sprite pixel write request.
- SX  in  XW  sprite pixel x.
- SD  in  DW  sprite pixel data.
- SRDY  out  1  write accepted when SREQ&SRDY.
- SDONE  in  1  one-cycle pulse when the renderer finishes its line.
- SSTART  out  1  one-cycle pulse telling the renderer to start the next line.
- LATE  out  1  one-cycle pulse when a bank swap occurs with no SDONE since the previous swap.
- BRA  out  XW+1  RAM read address.
- BRE  out  1  RAM read enable.
- BRD  in  DW  RAM read data, valid one cycle after BRE.
- BWA  out  XW+1  RAM write address.
- BWD  out  DW  RAM write data.
- BWE  out  1  RAM write enable.

## Operation
- State: BSEL (display bank), hblk_d (HBLK delayed), clr_pend, clr_addr, rd_pend, done_seen.
- Display read:
  - BRE = PCE & ~HBLK.
  - BRA = {BSEL, HPOS}, combinational.
- Erase: the cycle after any BRE, clr_pend=1 and clr_addr=previous BRA. While clr_pend is set, the write port writes TRANSP to clr_addr.
- Display output: DOUT <= BRD on the cycle after BRE; otherwise DOUT holds. DOUT <= TRANSP on the first cycle where HBLK is high.
- Sprite write:
  - SRDY = ~clr_pend & ~swap, where swap = HBLK & ~hblk_d.
  - On accept, BWA={~BSEL, SX}, BWD=SD, BWE = (SD != TRANSP).
  - A transparent pixel is acknowledged but not written.
  - Last write wins; the renderer orders sprites back-to-front.
- Bank swap: on the swap cycle, BSEL toggles at the clock edge.
  - SSTART pulses the following cycle.
  - LATE pulses the following cycle if done_seen=0.
  - done_seen clears on swap and sets on SDONE.
  - If SDONE and swap coincide, SDONE counts for the old line (no LATE).
- Write-port priority: erase > sprite. An unaccepted SREQ must hold SX/SD stable.
- SX wraps modulo 2^XW; no range check.

## Timing
- Reset values: BSEL=0, DOUT=TRANSP, SRDY=0, SSTART=0, LATE=0, BWE=0, clr_pend=0, done_seen=1, hblk_d=1.
- Read latency: BRE at cycle t, BRD at t+1, DOUT visible from t+2.
- Erase write for address read at t happens at t+1. Read and write to the same address in the same cycle never occur on the same bank side.
- Sprite throughput: one pixel per cycle when PCE=0. Worst case is PCE every cycle, giving 0 sprite writes; the renderer relies on HBLK for bandwidth.
- Swap cycle: SRDY=0. A request pending across the swap retargets the new ~BSEL; the renderer restarts on SSTART.
- Reset mid-line: all state returns to reset values and pending erases are dropped. RAM contents are not cleared; stale pixels may show for at most two lines until erase-after-read cleans both banks.
- PCE coincident with HBLK rising: no read. Swap proceeds.

## Structure
- Shared package holds XW, DW, TRANSP defaults and the bank-address concatenation helper, so the renderer and the mixer agree.
- Single module. An optional sub-module, linebuf_wrarb, contains the write-port mux and SRDY logic. No other hierarchy.

## Test plan
- Reset, then idle: all outputs at reset values. SRDY rises the cycle after RST_N deasserts, when clr_pend=0.
- Sprite write, then display:
  - Stimulus: BSEL=0, SX=5, SD=3 accepted, then HBLK rise.
  - Required: BSEL=1, SSTART pulses. On the next line, when HPOS=5 with PCE, DOUT=3 two cycles later. The erase write BWA={1,5}, BWD=0 occurs one cycle after the read.
- Erase priority: SREQ held high while PCE pulses every 2 cycles. SRDY is low exactly on the cycles after each PCE, and no SX/SD is lost.
- Transparent skip: SD=TRANSP accepted gives SRDY handshake with BWE=0.
- LATE: two HBLK rises with no SDONE between gives a LATE pulse on the second swap. With SDONE coincident with the swap, there is no LATE.
- Reset mid-line:
  - Stimulus: assert RST_N low with BSEL=1 and clr_pend=1.
  - Required: BSEL=0 and BWE=0 immediately (asynchronous). No erase write occurs after release.
